poly_select_streamer: RTL and testbench

//  Parametrised successor to the combinational polynomial selector. Selects one of NUM_IN

---
 rtl/poly_select_streamer_if.sv | 31 +++
 rtl/poly_select_streamer.sv | 116 +++++++++++
 tb/tb_poly_select_streamer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/poly_select_streamer_if.sv
// Handshake/bus bundle between the polynomial streamer and its requester/consumer.
interface poly_select_streamer_if #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned N       = 256,
  parameter int unsigned COEFF_W = 16,
  parameter int unsigned LANES   = 4,
  parameter int unsigned IDX_W   = 6
) ();
  logic                        start;
  logic [SEL_W-1:0]            sel;
  logic [NUM_IN*N*COEFF_W-1:0] in_polys;
  logic                        busy;
  logic                        err;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*COEFF_W-1:0]    out_data;
  logic [IDX_W-1:0]            out_idx;
  logic                        out_last;
  logic                        done;

  modport master (
    output start, sel, in_polys, out_ready,
    input  busy, err, out_valid, out_data, out_idx, out_last, done
  );

  modport slave (
    input  start, sel, in_polys, out_ready,
    output busy, err, out_valid, out_data, out_idx, out_last, done
  );
endinterface

// File: rtl/poly_select_streamer.sv
// Captures one of NUM_IN packed polynomials into a shadow register and streams it
// out LANES coefficients per beat over a valid/ready handshake.
module poly_select_streamer #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned N       = 256,
  parameter int unsigned COEFF_W = 16,
  parameter int unsigned LANES   = 4,
  parameter int unsigned IDX_W   = 6
) (
  input logic                    clk,
  input logic                    rst,
  poly_select_streamer_if.slave  bus
);
  localparam int unsigned BEATS  = N / LANES;
  localparam int unsigned POLY_W = N * COEFF_W;
  localparam int unsigned BEAT_W = LANES * COEFF_W;
  localparam logic [IDX_W-1:0] LastBeat = IDX_W'(BEATS - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [POLY_W-1:0]  shadow_q, shadow_d;
  logic [POLY_W-1:0]  sel_poly;
  logic [SEL_W-1:0]   sel;
  logic               sel_ok;
  logic               capture;
  logic               streaming;

  assign sel       = bus.sel;
  assign sel_ok    = 32'(sel) < NUM_IN;
  assign streaming = (state_q == StStream);

  // Input mux: only legal indices decode, so an illegal sel never reads past the bus.
  always_comb begin
    sel_poly = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(sel) == i) sel_poly = bus.in_polys[i*POLY_W +: POLY_W];
    end
  end

  // Next-state logic for the IDLE/STREAM controller, beat counter and pulses.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (sel_ok) begin
            capture = 1'b1;
            beat_d  = '0;
            state_d = StStream;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStream: begin
        // start is deliberately ignored here; sel is not sampled either.
        if (bus.out_ready) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shadow next value: load only on an accepted start, otherwise hold.
  always_comb begin
    shadow_d = shadow_q;
    if (capture) shadow_d = sel_poly;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Shadow storage needs no reset: its contents are gated off until a capture.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // Outputs decoded from state; data forced to zero whenever no beat is offered.
  always_comb begin
    bus.busy      = streaming;
    bus.out_valid = streaming;
    bus.out_idx   = beat_q;
    bus.out_last  = streaming && (beat_q == LastBeat);
    bus.out_data  = streaming ? shadow_q[32'(beat_q)*BEAT_W +: BEAT_W] : '0;
    bus.err       = err_q;
    bus.done      = done_q;
  end
endmodule

// File: tb/tb_poly_select_streamer.sv
// Randomized self-checking bench for poly_select_streamer against a coefficient-array model.
module tb_poly_select_streamer;
  localparam int NUM_IN  = 5;
  localparam int SEL_W   = 3;
  localparam int N       = 256;
  localparam int COEFF_W = 16;
  localparam int LANES   = 4;
  localparam int IDX_W   = 6;
  localparam int BEATS   = N / LANES;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [COEFF_W-1:0] coef [NUM_IN][N];

  poly_select_streamer_if #(
    .NUM_IN(NUM_IN), .SEL_W(SEL_W), .N(N), .COEFF_W(COEFF_W), .LANES(LANES), .IDX_W(IDX_W)
  ) bus_if ();

  poly_select_streamer #(
    .NUM_IN(NUM_IN), .SEL_W(SEL_W), .N(N), .COEFF_W(COEFF_W), .LANES(LANES), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat: lane k holds coefficient b*LANES+k of polynomial s.
  function automatic logic [63:0] exp_beat(input int s, input int b);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*COEFF_W +: COEFF_W] = coef[s][b*LANES + k];
    return r;
  endfunction

  task automatic randomize_polys();
    for (int i = 0; i < NUM_IN; i++)
      for (int j = 0; j < N; j++) coef[i][j] = COEFF_W'($urandom);
  endtask

  task automatic pack_polys();
    for (int i = 0; i < NUM_IN; i++)
      for (int j = 0; j < N; j++) bus_if.in_polys[(i*N + j)*COEFF_W +: COEFF_W] = coef[i][j];
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
    check_eq({tag, "_valid"}, 64'(bus_if.out_valid), 64'd0);
    check_eq({tag, "_data"}, 64'(bus_if.out_data), 64'd0);
    check_eq({tag, "_idx"}, 64'(bus_if.out_idx), 64'd0);
    check_eq({tag, "_last"}, 64'(bus_if.out_last), 64'd0);
  endtask

  // Called at a negedge; issues start and follows the whole stream to the done cycle.
  task automatic run_stream(input int s, input int pct, input bit zap);
    int beat;
    int cyc;
    int hs;
    bus_if.start     = 1'b1;
    bus_if.sel       = SEL_W'(s);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    bus_if.start = 1'b0;
    if (zap) bus_if.in_polys = '0;
    beat = 0;
    hs   = 0;
    while (beat < BEATS && cyc < 3000) begin
      check_eq("busy", 64'(bus_if.busy), 64'd1);
      check_eq("valid", 64'(bus_if.out_valid), 64'd1);
      check_eq("idx", 64'(bus_if.out_idx), 64'(beat));
      check_eq("data", 64'(bus_if.out_data), exp_beat(s, beat));
      check_eq("last", 64'(bus_if.out_last), 64'(beat == BEATS - 1));
      check_eq("no_err", 64'(bus_if.err), 64'd0);
      check_eq("no_done", 64'(bus_if.done), 64'd0);
      if (pct < 100) begin
        bus_if.start     = 1'($urandom_range(1));
        bus_if.sel       = SEL_W'($urandom_range(7));
        bus_if.out_ready = ($urandom_range(99) < pct);
      end else begin
        bus_if.out_ready = 1'b1;
      end
      if (bus_if.out_ready) begin
        beat++;
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    bus_if.start     = 1'b0;
    bus_if.out_ready = 1'b1;
    check_eq("handshakes", 64'(hs), 64'(BEATS));
    check_eq("done", 64'(bus_if.done), 64'd1);
    check_eq("done_err", 64'(bus_if.err), 64'd0);
    check_idle("done_cyc");
    if (pct >= 100) check_eq("latency", 64'(cyc), 64'(BEATS + 1));
    if (zap) pack_polys();
  endtask

  task automatic bad_start(input int s);
    bus_if.start = 1'b1;
    bus_if.sel   = SEL_W'(s);
    @(negedge clk);
    bus_if.start = 1'b0;
    check_eq("err_pulse", 64'(bus_if.err), 64'd1);
    check_eq("err_done", 64'(bus_if.done), 64'd0);
    check_idle("err_cyc");
    @(negedge clk);
    check_eq("err_clear", 64'(bus_if.err), 64'd0);
    check_idle("after_err");
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.sel       = '0;
    bus_if.out_ready = 1'b1;
    randomize_polys();
    pack_polys();
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_err", 64'(bus_if.err), 64'd0);
    check_eq("reset_done", 64'(bus_if.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic full-rate stream.
    run_stream(2, 100, 1'b0);
    @(negedge clk);

    // Back-to-back sweep, each start issued in the done cycle.
    for (int s = 0; s < NUM_IN; s++) run_stream(s, 100, 1'b0);
    @(negedge clk);

    // Illegal selectors, then a legal stream.
    bad_start(5);
    bad_start(7);
    run_stream(1, 100, 1'b0);
    @(negedge clk);

    // Random backpressure with ignored starts during the stream.
    randomize_polys();
    pack_polys();
    run_stream(4, 50, 1'b0);
    @(negedge clk);

    // Inputs wiped right after the accept edge.
    run_stream(3, 100, 1'b1);
    @(negedge clk);

    // Reset in the middle of a stream.
    bus_if.start = 1'b1;
    bus_if.sel   = SEL_W'(2);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("pre_rst_idx", 64'(bus_if.out_idx), 64'd20);
    check_eq("pre_rst_data", 64'(bus_if.out_data), exp_beat(2, 20));
    rst          = 1'b1;
    bus_if.start = 1'b1;
    bus_if.sel   = SEL_W'(1);
    @(negedge clk);
    rst          = 1'b0;
    bus_if.start = 1'b0;
    check_idle("rst_mid");
    check_eq("rst_err", 64'(bus_if.err), 64'd0);
    check_eq("rst_done", 64'(bus_if.done), 64'd0);
    @(negedge clk);
    check_eq("rst_no_done", 64'(bus_if.done), 64'd0);
    check_idle("rst_idle");
    run_stream(0, 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
